// File: rtl/vga_rx_if.sv
// VGA receive link: sync/colour inputs from the timing generator and the
// reconstructed pixel stream plus timing status going out.
interface vga_rx_if;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_color;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [10:0] h_period;
  logic [10:0] v_lines;

  modport master (
    output hs, vs, r, g, b,
    input  pix_valid, pix_x, pix_y, pix_color, frame_start, locked, err,
           h_period, v_lines
  );

  modport slave (
    input  hs, vs, r, g, b,
    output pix_valid, pix_x, pix_y, pix_color, frame_start, locked, err,
           h_period, v_lines
  );
endinterface

// File: rtl/vga_rx.sv
// VGA receiver: measures HS/VS timing, locks after consecutive good frames and
// rebuilds pixel coordinates so the incoming video can be checked or captured.
module vga_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_BACK      = 47,
  parameter int H_ACTIVE    = 640,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1600
) (
  input logic     clock,
  input logic     reset,
  vga_rx_if.slave link
);
  localparam logic [1:0]  SEARCH = 2'd0;
  localparam logic [1:0]  CHECK  = 2'd1;
  localparam logic [1:0]  LOCKED = 2'd2;
  localparam logic [10:0] H_TOTAL_W    = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W    = 11'(V_TOTAL);
  localparam logic [10:0] H_START      = 11'(H_BACK);
  localparam logic [10:0] H_END        = 11'(H_BACK + H_ACTIVE);
  localparam logic [10:0] V_START      = 11'(V_BACK);
  localparam logic [10:0] V_END        = 11'(V_BACK + V_ACTIVE);
  localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT - 1);
  localparam logic [7:0]  LOCK_N       = 8'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  logic        hs_p1, hs_p2, vs_p1, vs_p2;
  logic [11:0] rgb_p1, rgb_p2;
  logic [1:0]  primed;
  logic        hs_rise, vs_rise;

  logic [10:0] h_cnt, line, hs_in_frame, h_period_s, v_lines_s;
  logic        arm, h_seen, bad, locked_s, err_s;
  logic [1:0]  state;
  logic [7:0]  good_cnt;
  logic        timeout, line_bad, frame_good;

  logic        win;
  logic [9:0]  x_off, y_off;

  // Stage 1: input capture and delayed sync copies
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_p1  <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p1  <= 1'b0;
      vs_p2  <= 1'b0;
      rgb_p1 <= '0;
      rgb_p2 <= '0;
      primed <= '0;
    end else begin
      hs_p1  <= link.hs;
      hs_p2  <= hs_p1;
      vs_p1  <= link.vs;
      vs_p2  <= vs_p1;
      rgb_p1 <= {link.b, link.g, link.r};
      rgb_p2 <= rgb_p1;
      primed <= {primed[0], 1'b1};
    end
  end

  // A sync already high at reset release must not look like a rising edge.
  assign hs_rise = primed[1] & hs_p1 & ~hs_p2;
  assign vs_rise = primed[1] & vs_p1 & ~vs_p2;

  assign timeout    = ~hs_rise & (h_cnt == TIMEOUT_LAST);
  assign line_bad   = hs_rise & h_seen & (sat_inc(h_cnt) != H_TOTAL_W);
  assign frame_good = ~bad & (hs_in_frame == V_TOTAL_W);

  // Timing measurement and lock FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt       <= '0;
      line        <= '0;
      hs_in_frame <= '0;
      h_period_s  <= '0;
      v_lines_s   <= '0;
      arm         <= 1'b0;
      h_seen      <= 1'b0;
      bad         <= 1'b0;
      locked_s    <= 1'b0;
      err_s       <= 1'b0;
      state       <= SEARCH;
      good_cnt    <= '0;
    end else begin
      h_cnt <= hs_rise ? 11'd0 : sat_inc(h_cnt);
      if (hs_rise && h_seen) h_period_s <= sat_inc(h_cnt);
      if (timeout)      h_seen <= 1'b0;
      else if (hs_rise) h_seen <= 1'b1;

      // A coincident vs arms first, so that same HS becomes line 0.
      if (timeout) begin
        arm  <= 1'b0;
        line <= '0;
      end else if (hs_rise) begin
        if (arm || vs_rise) begin
          line <= '0;
          arm  <= 1'b0;
        end else begin
          line <= sat_inc(line);
        end
      end else if (vs_rise) begin
        arm <= 1'b1;
      end

      if (vs_rise) begin
        v_lines_s   <= hs_in_frame;
        hs_in_frame <= {10'd0, hs_rise};
        bad         <= line_bad;
      end else begin
        if (hs_rise)  hs_in_frame <= sat_inc(hs_in_frame);
        if (line_bad) bad <= 1'b1;
      end

      err_s <= 1'b0;
      if (timeout) begin
        state    <= SEARCH;
        locked_s <= 1'b0;
        err_s    <= 1'b1;
      end else if (vs_rise) begin
        case (state)
          SEARCH: begin
            good_cnt <= '0;
            state    <= CHECK;
          end
          CHECK: begin
            if (frame_good) begin
              good_cnt <= good_cnt + 8'd1;
              if (good_cnt + 8'd1 == LOCK_N) begin
                state    <= LOCKED;
                locked_s <= 1'b1;
              end
            end else begin
              err_s    <= 1'b1;
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!frame_good) begin
              err_s    <= 1'b1;
              locked_s <= 1'b0;
              state    <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign win   = locked_s & (h_cnt >= H_START) & (h_cnt < H_END) &
                 (line >= V_START) & (line < V_END);
  assign x_off = 10'(h_cnt - H_START);
  assign y_off = 10'(line - V_START);

  // Stage 2: output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      link.pix_valid   <= 1'b0;
      link.pix_x       <= '0;
      link.pix_y       <= '0;
      link.pix_color   <= '0;
      link.frame_start <= 1'b0;
      link.locked      <= 1'b0;
      link.err         <= 1'b0;
      link.h_period    <= '0;
      link.v_lines     <= '0;
    end else begin
      link.pix_valid   <= win;
      link.pix_x       <= win ? x_off : 10'd0;
      link.pix_y       <= win ? y_off : 10'd0;
      link.pix_color   <= win ? rgb_p2 : 12'd0;
      link.frame_start <= win & (x_off == 10'd0) & (y_off == 10'd0);
      link.locked      <= locked_s;
      link.err         <= err_s;
      link.h_period    <= h_period_s;
      link.v_lines     <= v_lines_s;
    end
  end
endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Receive side of the 640x480@60 VGA link. Consumes HS/VS/RGB as driven by the team's VGA timing generator, in the same 25 MHz pixel clock domain.
- Measures line and frame timing, locks when timing matches the expected totals, and reconstructs pixel coordinates.
- Emits a pixel stream (valid, x, y, color) for loopback self-test and for capture into pixel RAM.

Parameters:
- H_TOTAL, 800, expected clocks between consecutive HS rising edges.
- V_TOTAL, 525, expected HS rising edges between consecutive VS rising edges.
- H_BACK, 47, clocks from the first HS-high sample to the first active pixel sample.
- H_ACTIVE, 640, active pixels per line.
- V_BACK, 33, line index of the first active line.
- V_ACTIVE, 480, active lines per frame.
- LOCK_FRAMES, 2, consecutive good frames required to lock.
- TIMEOUT, 1600, clocks without an HS rising edge before lock is lost.

Ports:
- clock  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-high reset.
- hs  in  1  horizontal sync; low = pulse, rising edge = line reference.
- vs  in  1  vertical sync; low = pulse, rising edge = frame reference.
- r  in  4  red.
- g  in  4  green.
- b  in  4  blue.
- pix_valid  out  1  active pixel on pix_x/pix_y/pix_color this cycle.
- pix_x  out  10  column, 0..639.
- pix_y  out  10  row, 0..479.
- pix_color  out  12  {b,g,r}, matching the generator's bbbb_gggg_rrrr format.
- frame_start  out  1  one-cycle pulse coincident with pix_valid at x=0, y=0.
- locked  out  1  timing lock status.
- err  out  1  one-cycle pulse on a bad frame or timeout.
- h_period  out  11  last measured HS-to-HS period in clocks, saturating at 2047.
- v_lines  out  11  last measured HS count per frame, saturating at 2047.

Behaviour:
- Clock and reset: one clock (clock). reset is synchronous and active-high. While reset is high, all outputs and all state are 0 and the FSM is in SEARCH.
- Pipeline:
  - Stage 1 registers hs/vs/r/g/b (hs_q, vs_q, rgb_q) plus delayed copies (hs_qq, vs_qq).
  - Edge detect: hs_rise = hs_q & ~hs_qq; vs_rise likewise.
  - Stage 2 registers all outputs. An input sampled at edge t appears at the outputs after edge t+2.
- Horizontal counter h_cnt (11 bit):
  - Loads 0 on hs_rise, otherwise increments, saturating at 2047.
  - On hs_rise, h_period <= h_cnt + 1 (saturating).
  - The first hs_rise after reset or after a timeout only restarts h_cnt; it does not update h_period or check it.
- Line index line (11 bit):
  - vs_rise arms a clear. The first hs_rise at or after the arm sets line = 0; each later hs_rise increments line.
  - vs_rise and hs_rise on the same sample: the vs is processed first, so that HS is line 0.
- Pixel window:
  - Active when H_BACK <= h_cnt < H_BACK+H_ACTIVE and V_BACK <= line < V_BACK+V_ACTIVE.
  - pix_x = h_cnt - H_BACK; pix_y = line - V_BACK; pix_color = rgb_q.
  - pix_valid = window & locked. pix_x/pix_y/pix_color are 0 when pix_valid is 0.
- Frame check, evaluated at each vs_rise:
  - v_lines <= count of hs_rise since the previous vs_rise.
  - Frame is good iff v_lines == V_TOTAL and every h_period measured in the frame == H_TOTAL (sticky bad flag, cleared at vs_rise).
  - The first vs_rise after SEARCH entry only starts measurement; no good/bad verdict is issued.
- FSM:
  - SEARCH (reset state): on the first vs_rise, clear good_cnt and go to CHECK.
  - CHECK:
    - Good frame: good_cnt++; when good_cnt == LOCK_FRAMES, go to LOCKED and set locked = 1.
    - Bad frame: pulse err, set good_cnt = 0, stay in CHECK.
  - LOCKED:
    - Bad frame: pulse err, clear locked, go to SEARCH.
    - Good frame: stay in LOCKED.
  - Any state: if h_cnt reaches TIMEOUT, pulse err once, clear locked, go to SEARCH, clear the arm and line.
- frame_start = pix_valid & pix_x == 0 & pix_y == 0.
- Reset mid-frame: outputs are 0 at the next edge; relock follows the normal SEARCH sequence.

Test Plan:
- Nominal generator timing (800x525, H_BACK 47, V_BACK 33) from reset:
  - locked rises on the 3rd vs_rise + 2 clocks.
  - h_period = 800, v_lines = 525, err never pulses.
- Locked, color = {y[3:0], x[7:0]}:
  - Exactly 307200 pix_valid per frame and one frame_start.
  - Every pix_color matches its (pix_x, pix_y); the last pixel is (639, 479).
- One line stretched to 801 clocks while locked:
  - err pulses at the next vs_rise and locked falls.
  - Relock occurs 3 vs_rises later; pix_valid stays 0 meanwhile.
- HS held low while locked: err pulses and locked falls exactly 1600 clocks after the last hs_rise.
- reset pulsed mid-frame at line 200: all outputs 0 at the next edge; relock on the 3rd subsequent vs_rise.
- vs and hs rising on the same sample: that HS gives line 0; the first active line is the 34th HS, with pix_y = 0.
